// File: rtl/sd_card_file_writer.sv
// sd_card_file_writer
//
// Writes the 1-bit-per-cell frame RAM back to the SD card as one file of
// FILE_BLOCKS blocks. For each block it reads BLOCK_BITS cells into a local
// buffer (LSB-first within each byte), then streams the buffer to the SD
// block-write engine.
//
// Ports (all in the clk_ram domain):
//   clk_ram      sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   save         start pulse, accepted only when idle or finished
//   file_id      file number, latched when save is accepted
//   busy         high while a file save is in progress
//   save_finish  sticky: whole file written
//   save_error   sticky: engine reported an error and the save was aborted
//   address      RAM bit address
//   rden         RAM read enable; read_data returns one cycle later
//   read_data    RAM bit
//   blk_start    one-cycle request to the engine to begin a block write
//   blk_id       SD block number {file_id, block index}, zero-extended
//   byte_data    stream byte
//   byte_valid   stream valid
//   byte_ready   engine accepts a byte on byte_valid && byte_ready
//   blk_done     engine finished programming the block
//   blk_err      engine failed the block
module sd_card_file_writer #(
    parameter int FILE_BLOCKS = 128,
    parameter int BLOCK_BITS  = 4096,
    parameter int ADDR_W      = 24
) (
    input  logic              clk_ram,
    input  logic              reset_n,
    input  logic              save,
    input  logic [15:0]       file_id,
    output logic              busy,
    output logic              save_finish,
    output logic              save_error,
    output logic [ADDR_W-1:0] address,
    output logic              rden,
    input  logic              read_data,
    output logic              blk_start,
    output logic [31:0]       blk_id,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    input  logic              blk_done,
    input  logic              blk_err
);

    localparam int IDX_W  = $clog2(FILE_BLOCKS);
    localparam int BIT_W  = $clog2(BLOCK_BITS);
    localparam int BYTE_W = BIT_W - 3;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FILE_BLOCKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BLOCK_BITS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BLOCK_BITS / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        START,
        STREAM,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t              state;
    logic [15:0]         file_id_q;
    logic [IDX_W-1:0]    blk_idx;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [BLOCK_BITS-1:0] block_buf;

    // Read-return stage: marks which cell the RAM is presenting this cycle.
    logic                vld_p1;
    logic [BIT_W-1:0]    idx_p1;

    // Bit address of cell k in block blk; blocks are laid out back to back.
    function automatic logic [ADDR_W-1:0] ram_addr(input logic [IDX_W-1:0] blk,
                                                   input logic [BIT_W-1:0] k);
        return ADDR_W'({blk, k});
    endfunction

    function automatic logic [7:0] buf_byte(input logic [BLOCK_BITS-1:0] b,
                                            input logic [BYTE_W-1:0] i);
        return b[{i, 3'b000} +: 8];
    endfunction

    // The block buffer is pure data and needs no reset: every bit is
    // rewritten during FILL before it can be streamed.
    always_ff @(posedge clk_ram) begin
        if (vld_p1)
            block_buf[idx_p1] <= read_data;
    end

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            file_id_q   <= '0;
            blk_idx     <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            vld_p1      <= 1'b0;
            idx_p1      <= '0;
            busy        <= 1'b0;
            save_finish <= 1'b0;
            save_error  <= 1'b0;
            address     <= '0;
            rden        <= 1'b0;
            blk_start   <= 1'b0;
            blk_id      <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
        end else begin
            blk_start <= 1'b0;
            // The cell addressed this cycle is returned next cycle.
            vld_p1    <= rden;
            idx_p1    <= bit_cnt;

            if (blk_err && (state == START || state == STREAM || state == WAIT_DONE)) begin
                state      <= IDLE;
                save_error <= 1'b1;
                busy       <= 1'b0;
                byte_valid <= 1'b0;
                rden       <= 1'b0;
            end else begin
                case (state)
                    IDLE, FINISH: begin
                        if (save) begin
                            file_id_q   <= file_id;
                            blk_idx     <= '0;
                            bit_cnt     <= '0;
                            save_finish <= 1'b0;
                            save_error  <= 1'b0;
                            busy        <= 1'b1;
                            address     <= '0;
                            rden        <= 1'b1;
                            state       <= FILL;
                        end
                    end
                    FILL: begin
                        // bit_cnt always equals the low bits of address while issuing.
                        if (rden) begin
                            if (bit_cnt == BIT_LAST) begin
                                rden <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                address <= ram_addr(blk_idx, bit_cnt + BIT_W'(1));
                            end
                        end
                        if (vld_p1 && idx_p1 == BIT_LAST) begin
                            state     <= START;
                            blk_start <= 1'b1;
                            blk_id    <= 32'({file_id_q, blk_idx});
                        end
                    end
                    START: begin
                        byte_cnt   <= '0;
                        byte_data  <= buf_byte(block_buf, '0);
                        byte_valid <= 1'b1;
                        state      <= STREAM;
                    end
                    STREAM: begin
                        if (byte_valid && byte_ready) begin
                            if (byte_cnt == BYTE_LAST) begin
                                byte_valid <= 1'b0;
                                state      <= WAIT_DONE;
                            end else begin
                                byte_cnt  <= byte_cnt + BYTE_W'(1);
                                byte_data <= buf_byte(block_buf, byte_cnt + BYTE_W'(1));
                            end
                        end
                    end
                    WAIT_DONE: begin
                        if (blk_done) begin
                            if (blk_idx == IDX_LAST) begin
                                save_finish <= 1'b1;
                                busy        <= 1'b0;
                                state       <= FINISH;
                            end else begin
                                blk_idx <= blk_idx + IDX_W'(1);
                                bit_cnt <= '0;
                                address <= ram_addr(blk_idx + IDX_W'(1), '0);
                                rden    <= 1'b1;
                                state   <= FILL;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_card_file_writer.sv
// Testbench for sd_card_file_writer. The block size is reduced to 64 cells
// (8 bytes) so several full 128-block files fit in a short run; the file
// layout and block numbering are otherwise the full-size ones.
module tb_sd_card_file_writer;

    localparam int NB       = 128;
    localparam int BB       = 64;
    localparam int NBYTES   = BB / 8;
    localparam int DONE_DLY = 10;
    localparam int BUDGET   = 20000;

    logic        clk_ram = 1'b0;
    logic        reset_n = 1'b0;
    logic        save = 1'b0;
    logic [15:0] file_id = '0;
    logic        busy, save_finish, save_error;
    logic [23:0] address;
    logic        rden;
    logic        read_data = 1'b0;
    logic        blk_start;
    logic [31:0] blk_id;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        blk_done = 1'b0;
    logic        blk_err = 1'b0;

    sd_card_file_writer #(
        .FILE_BLOCKS(NB),
        .BLOCK_BITS (BB),
        .ADDR_W     (24)
    ) dut (
        .clk_ram    (clk_ram),
        .reset_n    (reset_n),
        .save       (save),
        .file_id    (file_id),
        .busy       (busy),
        .save_finish(save_finish),
        .save_error (save_error),
        .address    (address),
        .rden       (rden),
        .read_data  (read_data),
        .blk_start  (blk_start),
        .blk_id     (blk_id),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .blk_done   (blk_done),
        .blk_err    (blk_err)
    );

    always #5 clk_ram = ~clk_ram;

    int n_cmp = 0;
    int n_err = 0;

    // Environment knobs set by the stimulus process.
    int ram_mode  = 0;   // 0: addr%8==0, 1: address bit 4, 2: random image
    bit rnd_ready = 1'b0;
    bit spurious  = 1'b0;
    int err_blk   = -1;
    bit mem [0:NB*BB-1];

    // Scoreboard queues, filled when a save is issued.
    logic [31:0] exp_addr [$];
    logic [31:0] exp_blk  [$];
    logic [7:0]  exp_byte [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected/timeout, value 0x%0h at %0t", name, act, $time);
    endtask

    function automatic bit model_bit(input int a);
        case (ram_mode)
            0:       return (a % 8) == 0;
            1:       return ((a / 16) % 2) == 1;
            default: return mem[a % (NB*BB)];
        endcase
    endfunction

    // Whole-file expectation: every cell read in order, block numbers in
    // order, each byte built from 8 consecutive cells, lowest address in bit 0.
    task automatic push_file(input int fid);
        logic [7:0] v;
        for (int b = 0; b < NB; b++) begin
            exp_blk.push_back(32'(fid * NB + b));
            for (int k = 0; k < BB; k++)
                exp_addr.push_back(32'(b * BB + k));
            for (int j = 0; j < NBYTES; j++) begin
                for (int i = 0; i < 8; i++)
                    v[i] = model_bit(b * BB + 8 * j + i);
                exp_byte.push_back(v);
            end
        end
    endtask

    // RAM model: one cycle of read latency, garbage when not read.
    initial begin
        logic   prev_rden;
        int     prev_addr;
        prev_rden = 1'b0;
        prev_addr = 0;
        forever begin
            @(posedge clk_ram);
            #1;
            read_data = prev_rden ? model_bit(prev_addr) : 1'($urandom_range(0, 1));
            prev_rden = reset_n && rden;
            prev_addr = int'(address);
        end
    end

    // Block-write engine model.
    initial begin
        bit v, s, rd;
        int hs, dcnt, cur;
        hs = 0; dcnt = 0; cur = 0;
        forever begin
            @(negedge clk_ram);
            v  = byte_valid && byte_ready;
            s  = blk_start;
            rd = rden;
            @(posedge clk_ram);
            #1;
            blk_done   = 1'b0;
            blk_err    = 1'b0;
            byte_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!reset_n) begin
                hs = 0;
                dcnt = 0;
            end else begin
                if (s) begin
                    hs  = 0;
                    cur = int'(blk_id[6:0]);
                end
                if (v) begin
                    hs++;
                    if (hs == NBYTES) dcnt = DONE_DLY;
                end
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) blk_done = 1'b1;
                end else if (err_blk == cur && hs == 3 && !s) begin
                    blk_err = 1'b1;
                    err_blk = -1;
                    hs = 0;
                end else if (spurious && rd && $urandom_range(0, 31) == 0) begin
                    if ($urandom_range(0, 1) == 1) blk_done = 1'b1;
                    else                           blk_err  = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents something.
    initial begin
        logic       pst, perr, pbusy, blk_open;
        logic [7:0] pdata;
        logic [31:0] cur_id;
        int         hs_blk;
        pst = 0; perr = 0; pbusy = 0; blk_open = 0; pdata = '0; cur_id = '0; hs_blk = 0;
        forever begin
            @(negedge clk_ram);
            if (!reset_n) begin
                pst = 0; perr = 0; pbusy = 0; blk_open = 0; hs_blk = 0;
            end else begin
                if (rden) begin
                    if (exp_addr.size() == 0) fail_now("addr_extra", 32'(address));
                    else                      check("address", 32'(address), exp_addr.pop_front());
                end
                if (blk_start) begin
                    if (blk_open) check("handshakes_per_block", hs_blk, NBYTES);
                    if (exp_blk.size() == 0) fail_now("blk_start_extra", blk_id);
                    else                     check("blk_id", blk_id, exp_blk.pop_front());
                    cur_id   = blk_id;
                    hs_blk   = 0;
                    blk_open = 1'b1;
                end
                if (pst && !perr) begin
                    check("stall_valid_held", 32'(byte_valid), 1);
                    check("stall_data_held", 32'(byte_data), 32'(pdata));
                end
                if (byte_valid && byte_ready) begin
                    hs_blk++;
                    check("blk_id_stable", blk_id, cur_id);
                    if (exp_byte.size() == 0) fail_now("byte_extra", 32'(byte_data));
                    else                      check("byte_data", 32'(byte_data), 32'(exp_byte.pop_front()));
                end
                if (pbusy && !busy) begin
                    if (save_finish && blk_open) check("handshakes_last_block", hs_blk, NBYTES);
                    blk_open = 1'b0;
                end
                pst   = byte_valid && !byte_ready;
                pdata = byte_data;
                perr  = blk_err;
                pbusy = busy;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_address"},     32'(address), 0);
        check({tag, "_rden"},        32'(rden), 0);
        check({tag, "_blk_start"},   32'(blk_start), 0);
        check({tag, "_blk_id"},      blk_id, 0);
        check({tag, "_byte_data"},   32'(byte_data), 0);
        check({tag, "_byte_valid"},  32'(byte_valid), 0);
        check({tag, "_busy"},        32'(busy), 0);
        check({tag, "_save_finish"}, 32'(save_finish), 0);
        check({tag, "_save_error"},  32'(save_error), 0);
    endtask

    task automatic start_save(input int fid, input bit accept);
        if (accept) begin
            exp_addr.delete();
            exp_blk.delete();
            exp_byte.delete();
            push_file(fid);
        end
        @(posedge clk_ram);
        #1;
        file_id = fid[15:0];
        save    = 1'b1;
        @(posedge clk_ram);
        #1;
        save    = 1'b0;
        file_id = 16'($urandom);
        @(negedge clk_ram);
        check("busy_after_save", 32'(busy), 1);
        if (accept) begin
            check("finish_cleared", 32'(save_finish), 0);
            check("error_cleared", 32'(save_error), 0);
        end
    endtask

    task automatic wait_finish(input string tag);
        int t;
        t = 0;
        while (!save_finish && t < BUDGET) begin
            @(negedge clk_ram);
            t++;
        end
        if (t >= BUDGET) fail_now({tag, "_finish_timeout"}, t);
        check({tag, "_busy_low"}, 32'(busy), 0);
        check({tag, "_no_error"}, 32'(save_error), 0);
        check({tag, "_blocks_left"}, exp_blk.size(), 0);
        check({tag, "_bytes_left"}, exp_byte.size(), 0);
        check({tag, "_addrs_left"}, exp_addr.size(), 0);
        repeat (20) @(negedge clk_ram);
        check({tag, "_finish_sticky"}, 32'(save_finish), 1);
        check({tag, "_idle_after"}, 32'(busy), 0);
    endtask

    task automatic wait_fill_block(input int b, input string tag);
        int t;
        t = 0;
        while (!(rden && int'(address) >= b * BB && int'(address) < (b + 1) * BB) && t < BUDGET) begin
            @(negedge clk_ram);
            t++;
        end
        if (t >= BUDGET) fail_now({tag, "_fill_timeout"}, t);
    endtask

    initial begin
        #3_000_000;
        fail_now("watchdog", 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        for (int i = 0; i < NB * BB; i++) mem[i] = 1'($urandom_range(0, 1));

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(negedge clk_ram);
        check_all_zero("reset");
        @(posedge clk_ram);
        #1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk_ram);
        check("idle_busy", 32'(busy), 0);

        // Full save, one marker bit per byte.
        ram_mode = 0;
        start_save(3, 1'b1);
        wait_finish("full");

        // Packing pattern with random backpressure, restarted from FINISH.
        ram_mode  = 1;
        rnd_ready = 1'b1;
        start_save(1, 1'b1);
        wait_finish("backpressure");
        rnd_ready = 1'b0;

        // Busy lockout with stray done/err pulses during FILL.
        ram_mode = 2;
        spurious = 1'b1;
        start_save(2, 1'b1);
        wait_fill_block(5, "lockout");
        start_save(7, 1'b0);
        wait_finish("lockout");
        spurious = 1'b0;

        // Re-save with file 0 from FINISH.
        ram_mode = 0;
        start_save(0, 1'b1);
        wait_finish("resave");

        // Engine error in block 9.
        err_blk = 9;
        start_save(5, 1'b1);
        t = 0;
        while (!blk_err && t < BUDGET) begin
            @(negedge clk_ram);
            t++;
        end
        if (t >= BUDGET) fail_now("err_timeout", t);
        @(negedge clk_ram);
        check("err_save_error", 32'(save_error), 1);
        check("err_busy", 32'(busy), 0);
        check("err_byte_valid", 32'(byte_valid), 0);
        check("err_rden", 32'(rden), 0);
        check("err_no_finish", 32'(save_finish), 0);
        check("err_blocks_started", exp_blk.size(), NB - 10);
        repeat (10) @(negedge clk_ram);
        check("err_stays_idle", 32'(busy), 0);

        // Restart after error, then reset in the middle of block 2 FILL.
        ram_mode = 1;
        start_save(6, 1'b1);
        wait_fill_block(2, "reset");
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_addr.delete();
        exp_blk.delete();
        exp_byte.delete();
        repeat (3) @(posedge clk_ram);
        @(negedge clk_ram);
        reset_n = 1'b1;
        repeat (30) @(negedge clk_ram);
        check("post_reset_busy", 32'(busy), 0);
        check("post_reset_rden", 32'(rden), 0);
        check("post_reset_error", 32'(save_error), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
